// File: rtl/gen_debug_mux_pkg.sv
// Shared state encoding and parameter-derivation helpers for the debug scan mux.
package gen_debug_mux_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    HOLD   = 3'd2,
    SNAP   = 3'd3,
    SEND   = 3'd4
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Never returns less than 1 so single-entry selects still get a real bit.
  function automatic int clog2_min2(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/gen_debug_word_select.sv
// One-hot AND-OR picker of one OUT_W word from a zero-padded bus; purely combinational,
// no latency and no flow control.
module gen_debug_word_select #(
  parameter int OUT_W   = 32,
  parameter int N_WORDS = 4
) (
  input  logic [N_WORDS*OUT_W-1:0] padded_bus,
  input  logic [N_WORDS-1:0]       onehot,
  output logic [OUT_W-1:0]         word
);

  always_comb begin
    word = '0;
    for (int i = 0; i < N_WORDS; i++) begin
      word = word | (padded_bus[i*OUT_W +: OUT_W] & {OUT_W{onehot[i]}});
    end
  end

endmodule

// File: rtl/gen_multicycle_debug_scan_mux.sv
// Debug bus mux: static word select (2-cycle data, valid after MUX_LATENCY) or a snapshot
// scan that streams every word of one bus; only the scan stream honours out_ready.
module gen_multicycle_debug_scan_mux
  import gen_debug_mux_pkg::*;
#(
  parameter int  IN_DATA_BUS_WIDTH    = 100,
  parameter int  NUM_OF_IN_DATA_BUSES = 3,
  parameter int  OUT_DATA_BUS_WIDTH   = 32,
  parameter int  MUX_LATENCY          = 2,
  localparam int WPB                  = ceil_div(IN_DATA_BUS_WIDTH, OUT_DATA_BUS_WIDTH),
  localparam int DATA_SEL_OPTIONS     = NUM_OF_IN_DATA_BUSES * WPB,
  localparam int SEL_W                = clog2_min2(DATA_SEL_OPTIONS),
  localparam int BUS_W                = clog2_min2(NUM_OF_IN_DATA_BUSES),
  localparam int IDX_W                = clog2_min2(WPB)
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [NUM_OF_IN_DATA_BUSES*IN_DATA_BUS_WIDTH-1:0] in_data_bus,
  input  logic                                              mode,
  input  logic [SEL_W-1:0]                                  in_data_sel,
  input  logic [BUS_W-1:0]                                  scan_bus_sel,
  input  logic                                              scan_start,
  input  logic                                              out_ready,
  output logic [OUT_DATA_BUS_WIDTH-1:0]                     out_data_bus,
  output logic                                              out_valid,
  output logic [IDX_W-1:0]                                  out_word_idx,
  output logic                                              out_last,
  output logic                                              scan_busy
);

  localparam int IN    = IN_DATA_BUS_WIDTH;
  localparam int OUT   = OUT_DATA_BUS_WIDTH;
  localparam int NUM   = NUM_OF_IN_DATA_BUSES;
  localparam int PAD_W = WPB * OUT;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WPB - 1);
  localparam logic [3:0]       CNT_LAST = 4'(MUX_LATENCY - 1);

  state_t                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [DATA_SEL_OPTIONS-1:0] onehot_q, onehot_d, onehot_sel;
  logic [SEL_W-1:0]            sel_q, sel_d;
  logic                        mode_q;
  logic [IN-1:0]               snap_q, snap_d, bus_pick;
  logic [IDX_W-1:0]            scan_idx_q, scan_idx_d, nxt_idx, static_idx;
  logic [WPB-1:0]              snap_onehot;
  logic [NUM*PAD_W-1:0]        static_pad;
  logic [PAD_W-1:0]            snap_pad;
  logic [OUT-1:0]              static_word, snap_word, data_d;
  logic [IDX_W-1:0]            idx_d;
  logic                        valid_d, last_d, busy_d;
  logic                        sel_chg, scan_go;

  // Each bus is widened to WPB whole words; the top word's unused bits read as zero.
  always_comb begin
    static_pad = '0;
    for (int b = 0; b < NUM; b++) begin
      static_pad[b*PAD_W +: IN] = in_data_bus[b*IN +: IN];
    end
    snap_pad         = '0;
    snap_pad[IN-1:0] = snap_q;
  end

  always_comb begin
    bus_pick = '0;
    for (int b = 0; b < NUM; b++) begin
      if (scan_bus_sel == BUS_W'(b)) bus_pick = in_data_bus[b*IN +: IN];
    end
  end

  // Out-of-range selects decode to an all-zero one-hot, so the word reads as 0.
  always_comb begin
    for (int i = 0; i < DATA_SEL_OPTIONS; i++) begin
      onehot_sel[i] = (in_data_sel == SEL_W'(i));
    end
  end

  assign static_idx = IDX_W'(int'(in_data_sel) % WPB);
  assign nxt_idx    = (state_q == SEND) ? scan_idx_q + IDX_W'(1) : '0;

  always_comb begin
    for (int i = 0; i < WPB; i++) begin
      snap_onehot[i] = (nxt_idx == IDX_W'(i));
    end
  end

  gen_debug_word_select #(
    .OUT_W   (OUT),
    .N_WORDS (DATA_SEL_OPTIONS)
  ) u_static_sel (
    .padded_bus (static_pad),
    .onehot     (onehot_q),
    .word       (static_word)
  );

  gen_debug_word_select #(
    .OUT_W   (OUT),
    .N_WORDS (WPB)
  ) u_snap_sel (
    .padded_bus (snap_pad),
    .onehot     (snap_onehot),
    .word       (snap_word)
  );

  assign sel_chg = (in_data_sel != sel_q);
  // mode_q gate drops a start that arrives together with a mode change.
  assign scan_go = scan_start && mode && mode_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    onehot_d   = onehot_q;
    sel_d      = sel_q;
    snap_d     = snap_q;
    scan_idx_d = scan_idx_q;
    data_d     = out_data_bus;
    valid_d    = out_valid;
    idx_d      = out_word_idx;
    last_d     = out_last;
    busy_d     = scan_busy;
    case (state_q)
      IDLE, SETTLE, HOLD: begin
        if (scan_go && state_q != SETTLE) begin
          snap_d  = bus_pick;
          state_d = SNAP;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (mode) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else begin
          onehot_d = onehot_sel;
          sel_d    = in_data_sel;
          data_d   = static_word;
          idx_d    = static_idx;
          last_d   = 1'b0;
          if (state_q == IDLE || sel_chg) begin
            state_d = SETTLE;
            cnt_d   = '0;
            valid_d = 1'b0;
          end else if (state_q == SETTLE) begin
            if (cnt_q == CNT_LAST) begin
              state_d = HOLD;
              valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
      end
      SNAP: begin
        state_d    = SEND;
        scan_idx_d = nxt_idx;
        data_d     = snap_word;
        idx_d      = nxt_idx;
        last_d     = (nxt_idx == IDX_LAST);
        valid_d    = 1'b1;
      end
      SEND: begin
        if (out_ready) begin
          if (scan_idx_q == IDX_LAST) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
          end else begin
            scan_idx_d = nxt_idx;
            data_d     = snap_word;
            idx_d      = nxt_idx;
            last_d     = (nxt_idx == IDX_LAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      onehot_q     <= '0;
      sel_q        <= '0;
      mode_q       <= 1'b0;
      snap_q       <= '0;
      scan_idx_q   <= '0;
      out_data_bus <= '0;
      out_valid    <= 1'b0;
      out_word_idx <= '0;
      out_last     <= 1'b0;
      scan_busy    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      onehot_q     <= onehot_d;
      sel_q        <= sel_d;
      mode_q       <= mode;
      snap_q       <= snap_d;
      scan_idx_q   <= scan_idx_d;
      out_data_bus <= data_d;
      out_valid    <= valid_d;
      out_word_idx <= idx_d;
      out_last     <= last_d;
      scan_busy    <= busy_d;
    end
  end

endmodule

// File: doc/gen_multicycle_debug_scan_mux.md
GEN_MULTICYCLE_DEBUG_SCAN_MUX -- requirements
Module: gen_multicycle_debug_scan_mux

Interface
REQ-001 SHALL have parameter IN_DATA_BUS_WIDTH, default 100, width of each input debug bus.
REQ-002 SHALL have parameter NUM_OF_IN_DATA_BUSES, default 3, number of input buses.
REQ-003 SHALL have parameter OUT_DATA_BUS_WIDTH, default 32, output word width.
REQ-004 SHALL have parameter MUX_LATENCY, default 2, static-mode settle cycles; legal values are 2 to 15.
REQ-005 SHALL derive WPB = ceil(IN/OUT), DATA_SEL_OPTIONS = NUM*WPB, SEL_W = clog2(max(DATA_SEL_OPTIONS,2)), BUS_W = clog2(max(NUM,2)), IDX_W = clog2(max(WPB,2)).
REQ-006 clk  in  1  single clock; all logic is on the rising edge.
REQ-007 rst_n  in  1  reset; synchronous, active-low.
REQ-008 in_data_bus  in  NUM*IN  concatenated buses; bus 0 occupies the LSBs.
REQ-009 mode  in  1  0 = static select, 1 = scan.
REQ-010 in_data_sel  in  SEL_W  static word index (bus*WPB + word).
REQ-011 scan_bus_sel  in  BUS_W  bus to scan.
REQ-012 scan_start  in  1  single-cycle scan request.
REQ-013 out_ready  in  1  consumer ready; used in scan mode only.
REQ-014 out_data_bus  out  OUT  registered output word.
REQ-015 out_valid  out  1  static mode: data stable; scan mode: word offered.
REQ-016 out_word_idx  out  IDX_W  word index within the bus.
REQ-017 out_last  out  1  final word of a scan.
REQ-018 scan_busy  out  1  high while in SNAP or SEND.

Function
REQ-019 Word w of bus b SHALL equal bits [b*IN + w*OUT +: OUT] of that bus; the last word SHALL be zero-padded above bit (IN - (WPB-1)*OUT).
REQ-020 The FSM SHALL have states IDLE, SETTLE, HOLD, SNAP and SEND.
REQ-021 Static mode: the sel path SHALL register in_data_sel to a one-hot vector, then AND-OR select the word into out_data_bus, giving 2-cycle data latency.
REQ-022 Static mode: a change of in_data_sel, or entry from scan, SHALL move the FSM to SETTLE, clear out_valid and restart the settle counter.
REQ-023 Static mode: out_valid SHALL rise MUX_LATENCY cycles after the edge that sampled the new select, with the FSM then in HOLD.
REQ-024 Static mode: out_ready SHALL be ignored, and out_word_idx SHALL equal in_data_sel mod WPB.
REQ-025 An in_data_sel value at or above DATA_SEL_OPTIONS SHALL yield out_data_bus = 0 and normal out_valid timing.
REQ-026 scan_start with mode=1 in IDLE or HOLD SHALL snapshot the entire selected bus into an IN-bit register on that edge and enter SNAP.
REQ-027 SNAP SHALL last exactly one cycle and load word 0 with out_word_idx = 0, then enter SEND with out_valid = 1.
REQ-028 In SEND, out_data_bus, out_word_idx and out_last SHALL hold steady while out_valid=1 and out_ready=0.
REQ-029 In SEND, the handshake out_valid & out_ready SHALL advance to the next word on the next edge.
REQ-030 out_last SHALL be 1 only when out_word_idx = WPB-1.
REQ-031 A handshake on the last word SHALL return the FSM to IDLE with out_valid = 0 and scan_busy = 0.
REQ-032 A scan SHALL always emit exactly WPB words, and snapshot data SHALL be immune to in_data_bus changes during the scan.
REQ-033 scan_start while scan_busy=1 SHALL be ignored.
REQ-034 Changes to mode, scan_bus_sel or in_data_sel during a scan SHALL be ignored until the scan returns to IDLE.
REQ-035 A scan_bus_sel value at or above NUM SHALL scan all-zero words.
REQ-036 When mode=1 and the FSM is idle, out_valid SHALL be 0.
REQ-037 scan_start in the same cycle as a mode change SHALL be ignored.

Reset
REQ-038 While rst_n=0 at a clock edge, the FSM SHALL be forced to IDLE, and out_data_bus, out_valid, out_word_idx, out_last, scan_busy, the one-hot vector, the counter and the snapshot SHALL all be 0.
REQ-039 A reset mid-scan SHALL abort the scan with no further words emitted.
REQ-040 After rst_n deassertion with mode=0, the FSM SHALL enter SETTLE on the first edge.

Structure
REQ-041 Package gen_debug_mux_pkg SHALL hold the state enum and ceil-div/clog2 helper functions.
REQ-042 One sub-module, gen_debug_word_select, SHALL be used: combinational one-hot AND-OR word select from a padded bus.
REQ-043 gen_debug_word_select SHALL be instantiated for both the static path and the snapshot path.

Verification (default parameters: WPB=4, DATA_SEL_OPTIONS=12)
REQ-044 Static select: in_data_sel=5 with bus 1 = 100'h...; out_data_bus SHALL equal bus1[63:32] at cycle +2, with out_valid high at +2.
REQ-045 Select change: 5->11 while in HOLD; out_valid SHALL drop next cycle; at +2 out_data_bus SHALL equal {28'h0, bus2[99:96]} with out_valid=1.
REQ-046 Scan with bus 0, out_ready tied 1: SHALL emit 4 consecutive words, indices 0..3, out_last on index 3, then scan_busy=0.
REQ-047 Scan with backpressure: out_ready toggled every 2 cycles and in_data_bus randomised mid-scan; words SHALL hold while stalled and match the snapshot.
REQ-048 Boundaries: in_data_sel=13 SHALL output 0; scan_bus_sel=3 SHALL emit 4 zero words; scan_start while busy SHALL be ignored.
REQ-049 Reset at word 2 of a scan: all outputs SHALL be 0 on the next edge, and a new scan SHALL start cleanly.
